// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding, oversample ratio, default frame format.
// The TX side and the baud generator use the same defaults.
package uart_pkg;

    localparam int OVERSAMPLE       = 16;
    localparam int DEF_DATA_BITS    = 8;
    localparam int DEF_SB_TICKS     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // Counter width for a field of n values, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for one asynchronous input.
// The reset value is a parameter so idle-high lines do not glitch out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling; emits each good byte with a one-cycle strobe
// and flags frames whose stop bit is sampled low.
//
// state | meaning
// IDLE  | line idle, waiting for a low on rx_s
// START | counting to mid start bit; high there means a glitch
// DATA  | sampling data bits LSB first at mid bit
// STOP  | waiting SB_TICKS ticks, then checking the stop bit
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int SB_TICKS  = DEF_SB_TICKS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_rx,
    input  logic                 i_tick,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int              NW     = cnt_width(DATA_BITS);
    localparam logic [NW-1:0]   N_LAST = NW'(DATA_BITS - 1);
    localparam logic [3:0]      S_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]      S_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]      S_STOP = 4'(SB_TICKS - 1);

    logic                 rx_s;
    rx_state_t            state, state_nx;
    logic [3:0]           s, s_nx;
    logic [NW-1:0]        n, n_nx;
    logic [DATA_BITS-1:0] sh, sh_nx;
    logic [DATA_BITS-1:0] data_nx;
    logic                 done_nx, err_nx;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (i_rx),
        .q   (rx_s)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            s           <= '0;
            n           <= '0;
            sh          <= '0;
            o_data      <= '0;
            o_rx_done   <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nx;
            s           <= s_nx;
            n           <= n_nx;
            sh          <= sh_nx;
            o_data      <= data_nx;
            o_rx_done   <= done_nx;
            o_frame_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state;
        s_nx     = s;
        n_nx     = n;
        sh_nx    = sh;
        data_nx  = o_data;
        done_nx  = 1'b0;
        err_nx   = 1'b0;

        case (state)
            IDLE: begin
                // Leaving IDLE does not wait for a tick, so the start edge is caught promptly.
                if (!rx_s) begin
                    state_nx = START;
                    s_nx     = '0;
                end
            end
            START: begin
                if (i_tick) begin
                    if (s == S_MID) begin
                        if (!rx_s) begin
                            state_nx = DATA;
                            s_nx     = '0;
                            n_nx     = '0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
            DATA: begin
                if (i_tick) begin
                    if (s == S_LAST) begin
                        sh_nx = {rx_s, sh[DATA_BITS-1:1]};
                        s_nx  = '0;
                        if (n == N_LAST) begin
                            state_nx = STOP;
                        end else begin
                            n_nx = n + 1'b1;
                        end
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
            STOP: begin
                if (i_tick) begin
                    if (s == S_STOP) begin
                        state_nx = IDLE;
                        if (rx_s) begin
                            data_nx = sh;
                            done_nx = 1'b1;
                        end else begin
                            err_nx  = 1'b1;
                        end
                    end else begin
                        s_nx = s + 4'd1;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: tick every 4 clk, bit-level line stimulus,
// pulse counters sampled on the falling clock edge.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_rx = 1'b1;
    logic       i_tick;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    int tests = 0;
    int fails = 0;

    int unsigned cyc = 0;
    logic [1:0]  tdiv = 2'd0;
    int unsigned fall_cyc = 0;
    int unsigned done_cyc = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          both_cnt = 0;
    int          long_cnt = 0;
    logic        prev_done = 1'b0;
    logic        prev_err = 1'b0;
    logic [7:0]  rx_log[$];

    int base_done;
    int base_err;
    int unsigned lat;

    uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (i_rx),
        .i_tick      (i_tick),
        .o_data      (o_data),
        .o_rx_done   (o_rx_done),
        .o_frame_err (o_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        tdiv <= tdiv + 2'd1;
    end

    assign i_tick = (tdiv == 2'd3);

    always @(negedge clk) begin
        if (o_rx_done) begin
            done_cnt++;
            done_cyc = cyc;
            rx_log.push_back(o_data);
        end
        if (o_frame_err) err_cnt++;
        if (o_rx_done && o_frame_err) both_cnt++;
        if ((o_rx_done && prev_done) || (o_frame_err && prev_err)) long_cnt++;
        prev_done = o_rx_done;
        prev_err  = o_frame_err;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ticks(input int n);
        repeat (n * 4) @(negedge clk);
    endtask

    // Called at a falling clock edge; drives one 8N1 frame with the first
    // stop_low ticks of the stop bit forced low.
    task automatic send_frame(input logic [7:0] d, input int stop_low);
        i_rx     = 1'b0;
        fall_cyc = cyc;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            wait_ticks(16);
        end
        i_rx = 1'b0;
        wait_ticks(stop_low);
        i_rx = 1'b1;
        wait_ticks(16 - stop_low);
    endtask

    initial begin
        rst  = 1'b0;
        i_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_data", 32'(o_data), 32'h00);
        check("reset_done", 32'(o_rx_done), 32'h0);
        check("reset_err", 32'(o_frame_err), 32'h0);
        rst = 1'b1;
        wait_ticks(20);

        // Single 0xA5 frame and its latency from the falling start edge.
        base_done = done_cnt;
        base_err  = err_cnt;
        send_frame(8'hA5, 0);
        wait_ticks(4);
        lat = done_cyc - fall_cyc;
        check("a5_done_count", 32'(done_cnt - base_done), 32'd1);
        check("a5_data", 32'(o_data), 32'hA5);
        check("a5_err_count", 32'(err_cnt - base_err), 32'd0);
        check("a5_latency_608_611", 32'(lat >= 608 && lat <= 611), 32'd1);

        // Back-to-back command bytes with no idle gap.
        base_done = done_cnt;
        send_frame(8'h03, 0);
        send_frame(8'h07, 0);
        send_frame(8'h00, 0);
        wait_ticks(4);
        check("b2b_done_count", 32'(done_cnt - base_done), 32'd3);
        if (rx_log.size() >= 3) begin
            check("b2b_byte0", 32'(rx_log[rx_log.size()-3]), 32'h03);
            check("b2b_byte1", 32'(rx_log[rx_log.size()-2]), 32'h07);
            check("b2b_byte2", 32'(rx_log[rx_log.size()-1]), 32'h00);
        end else begin
            check("b2b_log_size", 32'(rx_log.size()), 32'd3);
        end

        // Three-tick low glitch must be rejected, then 0x5A received.
        base_done = done_cnt;
        base_err  = err_cnt;
        i_rx = 1'b0;
        wait_ticks(3);
        i_rx = 1'b1;
        wait_ticks(20);
        check("glitch_done_count", 32'(done_cnt - base_done), 32'd0);
        check("glitch_err_count", 32'(err_cnt - base_err), 32'd0);
        send_frame(8'h5A, 0);
        wait_ticks(4);
        check("post_glitch_done_count", 32'(done_cnt - base_done), 32'd1);
        check("post_glitch_data", 32'(o_data), 32'h5A);

        // 0xFF with the stop bit held low past its sample point.
        base_done = done_cnt;
        base_err  = err_cnt;
        send_frame(8'hFF, 12);
        wait_ticks(20);
        check("ferr_err_count", 32'(err_cnt - base_err), 32'd1);
        check("ferr_done_count", 32'(done_cnt - base_done), 32'd0);
        check("ferr_data_held", 32'(o_data), 32'h5A);

        // Reset after bit 4 of 0x3C; nothing reported, then 0xC3.
        base_done = done_cnt;
        base_err  = err_cnt;
        i_rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 5; i++) begin
            i_rx = logic'((8'h3C >> i) & 8'h01);
            wait_ticks(16);
        end
        rst  = 1'b0;
        i_rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid_data", 32'(o_data), 32'h00);
        check("rst_mid_done", 32'(o_rx_done), 32'h0);
        check("rst_mid_err", 32'(o_frame_err), 32'h0);
        rst = 1'b1;
        wait_ticks(20);
        check("rst_lost_frame_done", 32'(done_cnt - base_done), 32'd0);
        check("rst_lost_frame_err", 32'(err_cnt - base_err), 32'd0);
        send_frame(8'hC3, 0);
        wait_ticks(4);
        check("post_rst_done_count", 32'(done_cnt - base_done), 32'd1);
        check("post_rst_data", 32'(o_data), 32'hC3);

        // Break: line low ~3 frame times (ends early in the 4th START attempt).
        base_done = done_cnt;
        base_err  = err_cnt;
        i_rx = 1'b0;
        wait_ticks(460);
        i_rx = 1'b1;
        wait_ticks(24);
        check("break_err_count", 32'(err_cnt - base_err), 32'd3);
        check("break_done_count", 32'(done_cnt - base_done), 32'd0);
        check("break_data_held", 32'(o_data), 32'hC3);
        send_frame(8'h81, 0);
        wait_ticks(4);
        check("post_break_done_count", 32'(done_cnt - base_done), 32'd1);
        check("post_break_data", 32'(o_data), 32'h81);

        check("strobes_exclusive", 32'(both_cnt), 32'd0);
        check("strobes_single_cycle", 32'(long_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
